alu_control_seq: RTL and testbench



---
 rtl/alu_control_seq.sv | 149 ++++++++++++++
 tb/tb_alu_control_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// ALU control stage on the ID/EX boundary: decodes alu_op/funct into an ALU code
// and sequences the multi-cycle mult/div unit with a HI/LO interlock.
module alu_control_seq #(
    parameter int ALU_OP_WIDTH    = 3,
    parameter int FUNCT_WIDTH     = 6,
    parameter int OPERATION_WIDTH = 4,
    parameter int MULDIV_CYCLES   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_i,
    input  logic                       flush_i,
    input  logic [ALU_OP_WIDTH-1:0]    alu_op_i,
    input  logic [FUNCT_WIDTH-1:0]     alu_function_i,
    output logic [OPERATION_WIDTH-1:0] alu_operation_o,
    output logic                       valid_o,
    output logic                       stall_o,
    output logic                       muldiv_start_o,
    output logic                       muldiv_busy_o,
    output logic                       muldiv_done_o
);

    localparam int CW = $clog2(MULDIV_CYCLES + 1);
    localparam int OW = OPERATION_WIDTH;
    localparam int AW = ALU_OP_WIDTH;
    localparam int FW = FUNCT_WIDTH;

    localparam logic [AW-1:0] AOP_R    = AW'(3'b111);
    localparam logic [AW-1:0] AOP_ANDI = AW'(3'b010);
    localparam logic [AW-1:0] AOP_ADDI = AW'(3'b100);
    localparam logic [AW-1:0] AOP_LUI  = AW'(3'b000);
    localparam logic [AW-1:0] AOP_ORI  = AW'(3'b001);

    localparam logic [FW-1:0] F_ADD  = FW'(6'b100000);
    localparam logic [FW-1:0] F_SUB  = FW'(6'b100010);
    localparam logic [FW-1:0] F_OR   = FW'(6'b100101);
    localparam logic [FW-1:0] F_AND  = FW'(6'b100100);
    localparam logic [FW-1:0] F_NOR  = FW'(6'b100111);
    localparam logic [FW-1:0] F_SLL  = FW'(6'b000000);
    localparam logic [FW-1:0] F_SRL  = FW'(6'b000010);
    localparam logic [FW-1:0] F_MULT = FW'(6'b011000);
    localparam logic [FW-1:0] F_DIV  = FW'(6'b011010);
    localparam logic [FW-1:0] F_MFHI = FW'(6'b010000);
    localparam logic [FW-1:0] F_MFLO = FW'(6'b010010);

    localparam logic [OW-1:0] OP_INV = OW'(4'b1001);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] op_q, op_d;
    logic          valid_q, valid_d;
    logic          start_q, start_d;
    logic          done_q, done_d;

    logic [OW-1:0] dec_op;
    logic          dec_md;
    logic          dec_hl;
    logic          accept;

    always_comb begin
        dec_op = OP_INV;
        dec_md = 1'b0;
        dec_hl = 1'b0;
        if (alu_op_i == AOP_R) begin
            case (alu_function_i)
                F_ADD:  dec_op = OW'(4'b0011);
                F_SUB:  dec_op = OW'(4'b0101);
                F_OR:   dec_op = OW'(4'b0001);
                F_AND:  dec_op = OW'(4'b0110);
                F_NOR:  dec_op = OW'(4'b0111);
                F_SLL:  dec_op = OW'(4'b0010);
                F_SRL:  dec_op = OW'(4'b0100);
                F_MULT: begin dec_op = OW'(4'b1010); dec_md = 1'b1; end
                F_DIV:  begin dec_op = OW'(4'b1011); dec_md = 1'b1; end
                F_MFHI: begin dec_op = OW'(4'b1100); dec_hl = 1'b1; end
                F_MFLO: begin dec_op = OW'(4'b1101); dec_hl = 1'b1; end
                default: dec_op = OP_INV;
            endcase
        end else begin
            case (alu_op_i)
                AOP_ANDI: dec_op = OW'(4'b0110);
                AOP_ADDI: dec_op = OW'(4'b0011);
                AOP_LUI:  dec_op = OW'(4'b0000);
                AOP_ORI:  dec_op = OW'(4'b0001);
                default:  dec_op = OP_INV;
            endcase
        end
    end

    // Only HI/LO producers and consumers wait for the unit; others flow past.
    assign muldiv_busy_o = (state_q == BUSY);
    assign stall_o = muldiv_busy_o & valid_i & ~flush_i & (dec_md | dec_hl);
    assign accept  = valid_i & ~flush_i & ~stall_o;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_INV;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && dec_md) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        valid_d = accept;
        op_d    = accept ? dec_op : OP_INV;
        start_d = (state_q == IDLE) & accept & dec_md;
        done_d  = (state_q == BUSY) & (cnt_q == '0);
    end

    assign alu_operation_o = op_q;
    assign valid_o         = valid_q;
    assign muldiv_start_o  = start_q;
    assign muldiv_done_o   = done_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode table plus mult/div sequencing,
// interlock, flush and asynchronous reset corner cases (MULDIV_CYCLES=4).
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_i;
    logic       flush_i;
    logic [2:0] alu_op_i;
    logic [5:0] alu_function_i;
    logic [3:0] alu_operation_o;
    logic       valid_o;
    logic       stall_o;
    logic       muldiv_start_o;
    logic       muldiv_busy_o;
    logic       muldiv_done_o;

    int n_vec = 0;
    int n_err = 0;

    alu_control_seq #(
        .ALU_OP_WIDTH(3),
        .FUNCT_WIDTH(6),
        .OPERATION_WIDTH(4),
        .MULDIV_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid_i(valid_i),
        .flush_i(flush_i),
        .alu_op_i(alu_op_i),
        .alu_function_i(alu_function_i),
        .alu_operation_o(alu_operation_o),
        .valid_o(valid_o),
        .stall_o(stall_o),
        .muldiv_start_o(muldiv_start_o),
        .muldiv_busy_o(muldiv_busy_o),
        .muldiv_done_o(muldiv_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       f;
        logic [2:0] aop;
        logic [5:0] fn;
        logic [3:0] eop;
        logic       ev;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic [2:0] aop,
                         input logic [5:0] fn);
        @(negedge clk);
        valid_i = v;
        flush_i = f;
        alu_op_i = aop;
        alu_function_i = fn;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 3'b000, 6'b000000);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 3'b111, 6'b100000, 4'b0011, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 3'b001, 6'b000000, 4'b0001, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 3'b111, 6'b111111, 4'b1001, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 3'b111, 6'b100010, 4'b0101, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 3'b111, 6'b100101, 4'b0001, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 3'b111, 6'b100100, 4'b0110, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 3'b111, 6'b100111, 4'b0111, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 3'b111, 6'b000000, 4'b0010, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 3'b111, 6'b000010, 4'b0100, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 3'b111, 6'b010000, 4'b1100, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 3'b111, 6'b010010, 4'b1101, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 3'b010, 6'b011000, 4'b0110, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 3'b100, 6'b011010, 4'b0011, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 3'b000, 6'b100000, 4'b0000, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 3'b011, 6'b100000, 4'b1001, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 3'b101, 6'b011000, 4'b1001, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 3'b111, 6'b100000, 4'b1001, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 3'b111, 6'b100000, 4'b1001, 1'b0};

        reset = 1'b0;
        valid_i = 1'b0;
        flush_i = 1'b0;
        alu_op_i = 3'b000;
        alu_function_i = 6'b000000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_op", alu_operation_o, 4'b1001);
        chk("rst_valid", {3'b0, valid_o}, 4'd0);
        chk("rst_stall", {3'b0, stall_o}, 4'd0);
        chk("rst_busy", {3'b0, muldiv_busy_o}, 4'd0);
        chk("rst_start", {3'b0, muldiv_start_o}, 4'd0);
        chk("rst_done", {3'b0, muldiv_done_o}, 4'd0);

        // Decode table, FSM idle throughout
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].f, tbl[i].aop, tbl[i].fn);
            chk($sformatf("tbl%0d_stall", i), {3'b0, stall_o}, 4'd0);
            tick();
            chk($sformatf("tbl%0d_op", i), alu_operation_o, tbl[i].eop);
            chk($sformatf("tbl%0d_valid", i), {3'b0, valid_o}, {3'b0, tbl[i].ev});
            chk($sformatf("tbl%0d_busy", i), {3'b0, muldiv_busy_o}, 4'd0);
            chk($sformatf("tbl%0d_start", i), {3'b0, muldiv_start_o}, 4'd0);
        end

        // MULT then MFLO held through BUSY, including the last busy cycle
        drive(1'b1, 1'b0, 3'b111, 6'b011000);
        chk("mult_stall", {3'b0, stall_o}, 4'd0);
        tick();
        chk("mult_op", alu_operation_o, 4'b1010);
        chk("mult_valid", {3'b0, valid_o}, 4'd1);
        chk("mult_start", {3'b0, muldiv_start_o}, 4'd1);
        chk("mult_busy", {3'b0, muldiv_busy_o}, 4'd1);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0, 3'b111, 6'b010010);
            chk($sformatf("mflo%0d_stall", k), {3'b0, stall_o}, 4'd1);
            tick();
            chk($sformatf("mflo%0d_valid", k), {3'b0, valid_o}, 4'd0);
            chk($sformatf("mflo%0d_op", k), alu_operation_o, 4'b1001);
            chk($sformatf("mflo%0d_start", k), {3'b0, muldiv_start_o}, 4'd0);
            chk($sformatf("mflo%0d_busy", k), {3'b0, muldiv_busy_o},
                (k < 4) ? 4'd1 : 4'd0);
            chk($sformatf("mflo%0d_done", k), {3'b0, muldiv_done_o},
                (k < 4) ? 4'd0 : 4'd1);
        end
        drive(1'b1, 1'b0, 3'b111, 6'b010010);
        chk("mflo_go_stall", {3'b0, stall_o}, 4'd0);
        tick();
        chk("mflo_go_op", alu_operation_o, 4'b1101);
        chk("mflo_go_valid", {3'b0, valid_o}, 4'd1);
        chk("mflo_go_done", {3'b0, muldiv_done_o}, 4'd0);

        // MULT, ADD passes, flushed DIV, DIV stalled on last cycle then accepted
        drive(1'b1, 1'b0, 3'b111, 6'b011000);
        tick();
        chk("m2_start", {3'b0, muldiv_start_o}, 4'd1);
        drive(1'b1, 1'b0, 3'b111, 6'b100000);
        chk("add_busy_stall", {3'b0, stall_o}, 4'd0);
        tick();
        chk("add_busy_op", alu_operation_o, 4'b0011);
        chk("add_busy_valid", {3'b0, valid_o}, 4'd1);
        chk("add_busy_busy", {3'b0, muldiv_busy_o}, 4'd1);
        drive(1'b1, 1'b1, 3'b111, 6'b011010);
        chk("fl_busy_stall", {3'b0, stall_o}, 4'd0);
        tick();
        chk("fl_busy_valid", {3'b0, valid_o}, 4'd0);
        chk("fl_busy_busy", {3'b0, muldiv_busy_o}, 4'd1);
        idle_in();
        tick();
        chk("m2_c3_busy", {3'b0, muldiv_busy_o}, 4'd1);
        drive(1'b1, 1'b0, 3'b111, 6'b011010);
        chk("div_last_stall", {3'b0, stall_o}, 4'd1);
        tick();
        chk("m2_done", {3'b0, muldiv_done_o}, 4'd1);
        chk("m2_idle", {3'b0, muldiv_busy_o}, 4'd0);
        chk("div_last_valid", {3'b0, valid_o}, 4'd0);
        drive(1'b1, 1'b0, 3'b111, 6'b011010);
        chk("div_go_stall", {3'b0, stall_o}, 4'd0);
        tick();
        chk("div_go_op", alu_operation_o, 4'b1011);
        chk("div_go_start", {3'b0, muldiv_start_o}, 4'd1);
        chk("div_go_busy", {3'b0, muldiv_busy_o}, 4'd1);
        chk("div_go_done", {3'b0, muldiv_done_o}, 4'd0);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b1, 3'b111, 6'b010000);
            tick();
            chk($sformatf("dfl%0d_busy", k), {3'b0, muldiv_busy_o},
                (k < 4) ? 4'd1 : 4'd0);
            chk($sformatf("dfl%0d_done", k), {3'b0, muldiv_done_o},
                (k < 4) ? 4'd0 : 4'd1);
        end
        idle_in();
        tick();
        chk("dfl_done_pulse", {3'b0, muldiv_done_o}, 4'd0);

        // Flushed DIV in IDLE: nothing launches
        drive(1'b1, 1'b1, 3'b111, 6'b011010);
        tick();
        chk("idle_fl_valid", {3'b0, valid_o}, 4'd0);
        chk("idle_fl_start", {3'b0, muldiv_start_o}, 4'd0);
        chk("idle_fl_busy", {3'b0, muldiv_busy_o}, 4'd0);

        // Asynchronous reset in the middle of BUSY
        drive(1'b1, 1'b0, 3'b111, 6'b011000);
        tick();
        idle_in();
        tick();
        chk("pre_rst_busy", {3'b0, muldiv_busy_o}, 4'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", {3'b0, muldiv_busy_o}, 4'd0);
        chk("arst_start", {3'b0, muldiv_start_o}, 4'd0);
        chk("arst_op", alu_operation_o, 4'b1001);
        chk("arst_valid", {3'b0, valid_o}, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("post_rst%0d_done", k), {3'b0, muldiv_done_o}, 4'd0);
        end
        drive(1'b1, 1'b0, 3'b111, 6'b011000);
        tick();
        chk("post_mult_op", alu_operation_o, 4'b1010);
        chk("post_mult_start", {3'b0, muldiv_start_o}, 4'd1);
        chk("post_mult_busy", {3'b0, muldiv_busy_o}, 4'd1);
        idle_in();
        repeat (4) tick();
        chk("post_mult_done", {3'b0, muldiv_done_o}, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
